// File: rtl/instruction_fetch_unit.sv
// Opcode fetch front-end for the microcode sequencer: reads an opcode (optionally escape-prefixed)
// into ir/ir_page. Optional memory-wait timeout enabled with `define FETCH_TIMEOUT_EN.
module instruction_fetch_unit #(
  parameter logic [7:0] ESC_OPCODE = 8'hFD,
  parameter int         MAX_WAIT   = 15
) (
  input  logic       i_clk,
  input  logic       i_arst_n,
  input  logic       i_fetch_start,
  input  logic       i_flush,
  input  logic [7:0] i_mem_data,
  input  logic       i_mem_ready,
  output logic       o_mem_rd,
  output logic       o_pc_inc,
  output logic [7:0] o_ir,
  output logic       o_ir_page,
  output logic       o_ir_valid,
  output logic       o_busy,
  output logic       o_fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t     r_state;
  logic       r_esc;
  logic [7:0] r_ir;
  logic       r_ir_page;
  logic       w_in_req;
  logic       w_timeout;

  if (MAX_WAIT < 1) begin : g_bad_max_wait
    $error("instruction_fetch_unit: MAX_WAIT must be at least 1");
  end

  assign w_in_req = (r_state == REQ);

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = ($clog2(MAX_WAIT + 1) > 4) ? $clog2(MAX_WAIT + 1) : 4;

  logic [CW-1:0] r_wait_cnt;

  // Timeout fires on the wait cycle that would push the count past MAX_WAIT.
  assign w_timeout = w_in_req & ~i_mem_ready & ~i_flush & (r_wait_cnt == CW'(MAX_WAIT));

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n)
      r_wait_cnt <= '0;
    else if (w_in_req && !i_mem_ready && !i_flush && !w_timeout)
      r_wait_cnt <= r_wait_cnt + 1'b1;
    else
      r_wait_cnt <= '0;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      r_state   <= IDLE;
      r_esc     <= 1'b0;
      r_ir      <= 8'h00;
      r_ir_page <= 1'b0;
    end else if (i_flush) begin
      r_state <= IDLE;
      r_esc   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_fetch_start) begin
          r_state <= REQ;
          r_esc   <= 1'b0;
        end
        REQ: if (w_timeout) begin
          r_state <= IDLE;
          r_esc   <= 1'b0;
        end else if (i_mem_ready) begin
          // A second escape byte is taken as the opcode itself, never as another prefix.
          if (i_mem_data == ESC_OPCODE && !r_esc) begin
            r_esc <= 1'b1;
          end else begin
            r_ir      <= i_mem_data;
            r_ir_page <= r_esc;
            r_state   <= DONE;
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_mem_rd    = w_in_req;
  assign o_pc_inc    = w_in_req & i_mem_ready & ~i_flush;
  assign o_ir        = r_ir;
  assign o_ir_page   = r_ir_page;
  assign o_ir_valid  = (r_state == DONE);
  assign o_busy      = (r_state != IDLE);
  assign o_fetch_err = w_timeout;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed plus randomized fetches checked
// against a byte-sequence reference model.
module tb_instruction_fetch_unit;

  localparam logic [7:0] ESC = 8'hFD;
  localparam int         MW  = 15;

  logic       clk, arst_n;
  logic       fetch_start, flush, mem_ready;
  logic [7:0] mem_data;
  logic       mem_rd, pc_inc, ir_page, ir_valid, busy, fetch_err;
  logic [7:0] ir;

  int total = 0;
  int bad   = 0;

  instruction_fetch_unit #(.ESC_OPCODE(ESC), .MAX_WAIT(MW)) dut (
    .i_clk(clk), .i_arst_n(arst_n), .i_fetch_start(fetch_start), .i_flush(flush),
    .i_mem_data(mem_data), .i_mem_ready(mem_ready),
    .o_mem_rd(mem_rd), .o_pc_inc(pc_inc), .o_ir(ir), .o_ir_page(ir_page),
    .o_ir_valid(ir_valid), .o_busy(busy), .o_fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: a leading escape byte means two bytes are consumed and the second is the
  // opcode on page 1; otherwise the first byte is the page-0 opcode.
  task automatic do_fetch(input logic [7:0] b0, input logic [7:0] b1,
                          input int w0, input int w1, input bit hold, input string tag);
    logic [7:0] bytes [2];
    logic [7:0] exp_ir;
    logic       exp_pg;
    int p, exp_cyc, ncyc, npc, wl, idx;
    bit seen;
    bytes[0] = b0;
    bytes[1] = b1;
    p        = (b0 == ESC) ? 2 : 1;
    exp_ir   = (p == 2) ? b1 : b0;
    exp_pg   = (p == 2);
    exp_cyc  = 1 + p + w0 + ((p == 2) ? w1 : 0);
    @(negedge clk);
    chk({tag, "_idle_busy"}, busy, 0);
    fetch_start = 1'b1;
    mem_ready   = 1'b0;
    ncyc = 0; npc = 0; idx = 0; wl = w0; seen = 0;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      ncyc++;
      fetch_start = hold;
      mem_ready   = 1'b0;
      mem_data    = 8'($urandom);
      if (ir_valid) begin
        seen = 1;
        chk({tag, "_ir"}, ir, exp_ir);
        chk({tag, "_page"}, ir_page, exp_pg);
        chk({tag, "_latency"}, ncyc, exp_cyc);
        chk({tag, "_pc_inc"}, npc, p);
      end else if (mem_rd) begin
        if (wl > 0) wl--;
        else begin
          mem_ready = 1'b1;
          mem_data  = bytes[idx];
          idx = (idx < 1) ? idx + 1 : 1;
          wl  = w1;
        end
        #1;
        if (pc_inc) npc++;
      end
    end
    if (!seen) chk({tag, "_no_ir_valid"}, 0, 1);
    mem_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] b0, b1;
    arst_n = 1'b0; fetch_start = 1'b0; flush = 1'b0; mem_ready = 1'b0; mem_data = 8'h00;
    #12;
    chk("rst_ir", ir, 8'h00);
    chk("rst_page", ir_page, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_fetch_err", fetch_err, 0);
    @(negedge clk); arst_n = 1'b1;

    // Directed fetches
    do_fetch(8'h27, 8'h00, 0, 0, 0, "single");
    do_fetch(ESC, 8'h11, 0, 2, 0, "esc_wait");
    do_fetch(ESC, ESC, 1, 0, 0, "dbl_esc");

    // Reset while mid-fetch
    do_fetch(8'h3C, 8'h00, 0, 0, 0, "load3c");
    @(negedge clk); fetch_start = 1'b1;
    @(negedge clk); fetch_start = 1'b0;
    chk("pre_rst_mem_rd", mem_rd, 1);
    arst_n = 1'b0; #1;
    chk("mid_rst_ir", ir, 8'h00);
    chk("mid_rst_mem_rd", mem_rd, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ir_valid", ir_valid, 0);
    @(negedge clk); arst_n = 1'b1;

    // Flush coinciding with valid data
    do_fetch(8'hA5, 8'h00, 0, 0, 0, "loada5");
    @(negedge clk); fetch_start = 1'b1;
    @(negedge clk); fetch_start = 1'b0;
    flush = 1'b1; mem_ready = 1'b1; mem_data = 8'h55; #1;
    chk("flush_pc_inc", pc_inc, 0);
    @(negedge clk); flush = 1'b0; mem_ready = 1'b0;
    chk("flush_busy", busy, 0);
    chk("flush_ir", ir, 8'hA5);
    chk("flush_ir_valid", ir_valid, 0);

    // Flush after a prefix must drop the page selection
    @(negedge clk); fetch_start = 1'b1;
    @(negedge clk); fetch_start = 1'b0; mem_ready = 1'b1; mem_data = ESC; #1;
    chk("esc_pc_inc", pc_inc, 1);
    @(negedge clk); mem_ready = 1'b0; flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("esc_flush_busy", busy, 0);
    do_fetch(8'h22, 8'h00, 0, 0, 0, "after_esc_flush");

`ifdef FETCH_TIMEOUT_EN
    do_fetch(8'h6B, 8'h00, 0, 0, 0, "load6b");
    @(negedge clk); fetch_start = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); fetch_start = 1'b0; mem_ready = 1'b0;
      chk($sformatf("tmo_err_c%0d", k), fetch_err, (k == 16));
    end
    @(negedge clk);
    chk("tmo_busy", busy, 0);
    chk("tmo_ir", ir, 8'h6B);
    chk("tmo_ir_valid", ir_valid, 0);
    chk("tmo_err_clr", fetch_err, 0);
`else
    @(negedge clk); fetch_start = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk); fetch_start = 1'b0; mem_ready = 1'b0;
      chk($sformatf("nto_rd_c%0d", k), mem_rd, 1);
      chk($sformatf("nto_err_c%0d", k), fetch_err, 0);
    end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    chk("nto_flush_busy", busy, 0);
`endif

    // Back-to-back with fetch_start held high; busy-time requests must be ignored
    do_fetch(8'h01, 8'h00, 0, 0, 1, "b2b_01");
    do_fetch(8'h02, 8'h00, 0, 0, 1, "b2b_02");
    do_fetch(8'h03, 8'h00, 0, 0, 0, "b2b_03");

    // Randomized fetches
    for (int n = 0; n < 25; n++) begin
      b0 = ($urandom_range(0, 1) == 1) ? ESC : 8'($urandom);
      b1 = ($urandom_range(0, 4) == 0) ? ESC : 8'($urandom);
      do_fetch(b0, b1, $urandom_range(0, 5), $urandom_range(0, 5), 0, $sformatf("rnd%0d", n));
    end

    @(negedge clk);
    chk("end_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
Upstream feeder of the microcode sequencer. It fetches the opcode byte, or an escape prefix plus opcode, from the memory data bus when the sequencer enters fetch. It latches the opcode into the instruction register (ir) and an opcode-page bit. Together these form the sequencer's opcode dispatch address ({ir_page, ir}). It also pulses pc_inc once per byte consumed.

Parameters:
ESC_OPCODE, 8'hFD, byte value treated as escape prefix (selects page 1)
MAX_WAIT, 15, memory wait-cycle limit per byte; used only with FETCH_TIMEOUT_EN

Ports:
clk  input  1  system clock, rising edge
arst_n  input  1  asynchronous active-low reset
fetch_start  input  1  request a new opcode fetch; sampled only in IDLE
flush  input  1  abort any fetch in progress, synchronous
mem_data  input  8  memory read data bus
mem_ready  input  1  memory has valid data this cycle (inverse of WAIT)
mem_rd  output  1  memory read strobe
pc_inc  output  1  one-cycle pulse per byte accepted; PC advances
ir  output  8  instruction register
ir_page  output  1  1 = opcode followed an escape prefix
ir_valid  output  1  one-cycle pulse: new ir/ir_page available
busy  output  1  fetch in progress (state != IDLE)
fetch_err  output  1  one-cycle timeout pulse; tied 0 without FETCH_TIMEOUT_EN

Behaviour:
- Reset (arst_n=0, async): state=IDLE, ir=8'h00, ir_page=0, esc flag=0, wait counter=0; ir_valid=0, fetch_err=0, mem_rd=0, busy=0.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - fetch_start=1 -> REQ; clear esc flag.
  - Otherwise stay.
- REQ:
  - mem_rd=1 (combinational from state).
  - pc_inc = (state==REQ) & mem_ready & ~flush (combinational).
  - mem_ready=0: stay.
  - mem_ready=1, mem_data==ESC_OPCODE, esc=0: set esc=1; stay REQ to fetch the second byte; ir unchanged.
  - mem_ready=1, any other case: ir<=mem_data, ir_page<=esc; go to DONE.
  - Double escape (esc=1, byte==ESC_OPCODE): latched as opcode ESC_OPCODE, page 1. No re-escape.
- DONE:
  - ir_valid=1 for exactly this cycle; next state IDLE.
  - fetch_start in DONE is ignored; the requester must re-assert it in IDLE.
- Latency: fetch_start sampled at edge N; mem_rd high from cycle N+1.
  - With zero wait and no prefix: ir updates at edge N+2, ir_valid high in cycle N+2, IDLE at N+3.
  - Each prefix byte adds 1 cycle; each wait cycle adds 1 cycle.
- flush:
  - Highest priority: any state -> IDLE at the next edge.
  - esc cleared; ir/ir_page unchanged.
  - No pc_inc or ir_valid in the flush cycle.
- fetch_start is ignored while busy=1.
- ir/ir_page hold their value between fetches.
- busy = (state != IDLE).

Optional Feature:
FETCH_TIMEOUT_EN
- Defined:
  - A 4-bit-minimum wait counter (sized for MAX_WAIT) increments each REQ cycle with mem_ready=0.
  - It clears on every accepted byte and on leaving REQ.
  - When the counter equals MAX_WAIT and mem_ready=0: fetch_err pulses 1 cycle, state goes to IDLE, esc is cleared, ir is unchanged, and no ir_valid is produced.
  - flush takes priority over timeout.
- Undefined: no counter; fetch_err is constant 0; REQ waits indefinitely.

Test Plan:
- Reset mid-fetch: assert arst_n=0 while in REQ with ir=8'h3C loaded -> immediately ir=8'h00, mem_rd=0, busy=0, ir_valid=0.
- Single-byte opcode, zero wait: fetch_start at edge 0, mem_ready=1, mem_data=8'h27 -> mem_rd and pc_inc high in cycle 1; ir=8'h27, ir_page=0, ir_valid=1 in cycle 2; busy=0 in cycle 3.
- Escape prefix with 2 wait cycles on the second byte: bytes 8'hFD then 8'h11 -> exactly 2 pc_inc pulses, ir=8'h11, ir_page=1, ir_valid in cycle 5. Also drive 8'hFD, 8'hFD -> ir=8'hFD, ir_page=1.
- flush in the same cycle as mem_ready=1, mem_data=8'h55 -> no pc_inc, ir keeps its prior value, IDLE next cycle, no ir_valid. A fetch_start asserted while busy produces no second fetch.
- With FETCH_TIMEOUT_EN, MAX_WAIT=15: mem_ready held 0 -> fetch_err pulse in the 16th REQ cycle, then IDLE, ir unchanged. Without the macro, the unit stays in REQ for 100 cycles and fetch_err stays 0.
- Back-to-back: fetch_start held high continuously, mem_ready=1, data 8'h01, 8'h02, 8'h03 -> fetches start every 3 cycles; ir_valid pulses show 01, 02, 03 in order.
